int_alu_exec: RTL and testbench

Integer ALU execute stage directly downstream of the integer reservation station. It accepts one issued uop per cycle together with its PRF operand values, computes the ALU result, and buffers results in a small in-order queue. Results then win a slot on the shared CDB through a request/grant handshake, and the stage broadcasts them to the ROB, the PRF and the snooping reservation stations.

---
 rtl/int_alu_exec_if.sv | 18 +
 rtl/int_alu_exec.sv | 147 ++++++++++++++
 tb/tb_int_alu_exec.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_alu_exec_if.sv
// CDB broadcast bundle driven by the integer ALU execute stage.
// The fu/master side drives every field; snoopers (ROB, PRF, RS) use slave.
interface cdb_itf #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 6,
  parameter int PHY_W    = 7,
  parameter int ARCH_W   = 5
);
  logic                valid;
  logic [ROB_ID_W-1:0] rob_id;
  logic [PHY_W-1:0]    rd_phy;
  logic [ARCH_W-1:0]   rd_arch;
  logic [XLEN-1:0]     rd_value;

  modport fu     (output valid, rob_id, rd_phy, rd_arch, rd_value);
  modport master (output valid, rob_id, rd_phy, rd_arch, rd_value);
  modport slave  (input  valid, rob_id, rd_phy, rd_arch, rd_value);
endinterface

// File: rtl/int_alu_exec.sv
// Integer ALU execute stage: computes results for issued uops, buffers them in
// an in-order queue and broadcasts them on the CDB under request/grant control.
package int_alu_exec_pkg;
  localparam int XLEN     = 32;
  localparam int ROB_ID_W = 6;
  localparam int PHY_W    = 7;
  localparam int ARCH_W   = 5;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_ZERO = 2'd1;
  localparam logic [1:0] OP1_PC   = 2'd2;
  localparam logic       OP2_RS2  = 1'b0;
  localparam logic       OP2_IMM  = 1'b1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [PHY_W-1:0]    rd_phy;
    logic [ARCH_W-1:0]   rd_arch;
    logic [1:0]          op1_sel;
    logic                op2_sel;
    logic [3:0]          fu_opcode;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rs1_value;
    logic [XLEN-1:0]     rs2_value;
  } fu_alu_reg_t;
endpackage

module int_alu_exec
  import int_alu_exec_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int XLEN   = int_alu_exec_pkg::XLEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_rs_valid,
  output logic        fu_alu_ready,
  input  fu_alu_reg_t fu_alu_reg_in,
  output logic        cdb_req,
  input  logic        cdb_grant,
  cdb_itf.fu          cdb
);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [PHY_W-1:0]    rd_phy;
    logic [ARCH_W-1:0]   rd_arch;
    logic [XLEN-1:0]     value;
  } entry_t;

  entry_t           queue_q [QDEPTH];
  entry_t           entry_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             acc, pop;
  logic [XLEN-1:0]  op_a, op_b, result;
  logic [4:0]       shamt;

  // Handshakes: a uop transfers on a rising edge where int_rs_valid and
  // fu_alu_ready are both high; a result transfers where cdb_req and
  // cdb_grant are both high (cdb.valid). Ready and req come only from count_q.
  assign fu_alu_ready = (count_q < CNT_W'(QDEPTH));
  assign cdb_req      = (count_q != '0);
  assign acc          = int_rs_valid & fu_alu_ready;
  assign pop          = cdb_req & cdb_grant;

  always_comb begin
    op_a = '0;
    case (fu_alu_reg_in.op1_sel)
      OP1_RS1: op_a = fu_alu_reg_in.rs1_value;
      OP1_PC:  op_a = fu_alu_reg_in.pc;
      default: op_a = '0;
    endcase
    op_b  = (fu_alu_reg_in.op2_sel == OP2_IMM) ? fu_alu_reg_in.imm : fu_alu_reg_in.rs2_value;
    shamt = op_b[4:0];
  end

  always_comb begin
    result = '0;
    case (fu_alu_reg_in.fu_opcode)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  result = op_a ^ op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      default:  result = '0;
    endcase
  end

  always_comb begin
    entry_d         = '0;
    entry_d.rob_id  = fu_alu_reg_in.rob_id;
    entry_d.rd_phy  = fu_alu_reg_in.rd_phy;
    entry_d.rd_arch = fu_alu_reg_in.rd_arch;
    entry_d.value   = result;
  end

  // QDEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(acc) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset; count_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (acc) queue_q[wr_ptr_q] <= entry_d;
  end

  assign cdb.valid    = pop;
  assign cdb.rob_id   = queue_q[rd_ptr_q].rob_id;
  assign cdb.rd_phy   = queue_q[rd_ptr_q].rd_phy;
  assign cdb.rd_arch  = queue_q[rd_ptr_q].rd_arch;
  assign cdb.rd_value = queue_q[rd_ptr_q].value;
endmodule

// File: tb/tb_int_alu_exec.sv
// Self-checking bench for int_alu_exec: directed ALU vectors, backpressure,
// push/pop overlap, pointer wrap and reset, with a CDB scoreboard.
module tb_int_alu_exec;
  import int_alu_exec_pkg::*;

  localparam int EW = ROB_ID_W + PHY_W + ARCH_W + XLEN;

  logic        clk;
  logic        rst;
  logic        int_rs_valid;
  logic        fu_alu_ready;
  fu_alu_reg_t fu_alu_reg_in;
  logic        cdb_req;
  logic        cdb_grant;

  cdb_itf cdb_bus ();

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  int_alu_exec #(.QDEPTH(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .int_rs_valid (int_rs_valid),
    .fu_alu_ready (fu_alu_ready),
    .fu_alu_reg_in(fu_alu_reg_in),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb          (cdb_bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every broadcast must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (cdb_bus.valid !== (cdb_req & cdb_grant)) begin
        errors++;
        $display("FAIL cdb_valid_rule got %b exp %b", cdb_bus.valid, cdb_req & cdb_grant);
      end
      if (cdb_bus.valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cdb_unexpected got rob %0d value %h exp nothing",
                   cdb_bus.rob_id, cdb_bus.rd_value);
        end else begin
          logic [EW-1:0] got, exp;
          got = {cdb_bus.rob_id, cdb_bus.rd_phy, cdb_bus.rd_arch, cdb_bus.rd_value};
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL cdb_entry got %h exp %h", got, exp);
          end
        end
      end
    end
  end

  function automatic fu_alu_reg_t mk(input int rob, input logic [1:0] s1, input logic s2,
                                     input logic [3:0] opc, input logic [31:0] imm,
                                     input logic [31:0] pc, input logic [31:0] rs1,
                                     input logic [31:0] rs2);
    fu_alu_reg_t u;
    u.rob_id    = ROB_ID_W'(rob);
    u.rd_phy    = PHY_W'(rob * 3 + 1);
    u.rd_arch   = ARCH_W'(rob + 2);
    u.op1_sel   = s1;
    u.op2_sel   = s2;
    u.fu_opcode = opc;
    u.imm       = imm;
    u.pc        = pc;
    u.rs1_value = rs1;
    u.rs2_value = rs2;
    return u;
  endfunction

  // Reference ALU used for randomised uops
  function automatic logic [31:0] model(input fu_alu_reg_t u);
    logic [31:0] a, b;
    logic [63:0] ext;
    logic [4:0]  s;
    a = (u.op1_sel == OP1_RS1) ? u.rs1_value : (u.op1_sel == OP1_PC) ? u.pc : 32'd0;
    b = u.op2_sel ? u.imm : u.rs2_value;
    s = b[4:0];
    ext = {{32{a[31]}}, a} >> s;
    case (u.fu_opcode)
      4'd0: return a + b;
      4'd1: return a + ~b + 32'd1;
      4'd2: return a << s;
      4'd3: return a >> s;
      4'd4: return ext[31:0];
      4'd5: return (a[31] ^ b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd6: return {31'd0, a < b};
      4'd7: return a ^ b;
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic fu_alu_reg_t rand_uop(input int rob);
    return mk(rob, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 11)), $urandom, $urandom, $urandom, $urandom);
  endfunction

  // Driver: present a uop (at posedge+1) until accepted, then return at posedge+1
  task automatic issue(input fu_alu_reg_t u, input logic [31:0] expv);
    int waited = 0;
    int_rs_valid  = 1'b1;
    fu_alu_reg_in = u;
    @(negedge clk);
    while (fu_alu_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (fu_alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_accept got ready %b exp 1 (rob %0d)", fu_alu_ready, u.rob_id);
    end else begin
      exp_q.push_back({u.rob_id, u.rd_phy, u.rd_arch, expv});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    int_rs_valid = 1'b0;
    cdb_grant    = 1'b1;
    @(negedge clk);
    while (cdb_req === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    fu_alu_reg_t u;
    u = mk(1, OP1_RS1, OP2_RS2, ALU_ADD, 0, 0, 32'd2, 32'd3);
    rst = 1'b1; int_rs_valid = 1'b1; fu_alu_reg_in = u; cdb_grant = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (fu_alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fu_alu_ready); end
    checks++;
    if (cdb_req !== 1'b0) begin errors++; $display("FAIL reset_cdb_req got %b exp 0", cdb_req); end
    checks++;
    if (cdb_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_cdb_valid got %b exp 0", cdb_bus.valid); end
    // uop held through reset is taken on the first edge after release
    exp_q.push_back({u.rob_id, u.rd_phy, u.rd_arch, 32'd5});
    rst = 1'b0;
    @(posedge clk); #1;
    int_rs_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cdb_bus.valid !== 1'b1) begin errors++; $display("FAIL reset_first_accept got %b exp 1", cdb_bus.valid); end
    @(posedge clk); #1;
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_alu_ops();
    fu_alu_reg_t u [10];
    logic [31:0] ev [10];
    u[0] = mk(2,  OP1_RS1,  OP2_RS2, ALU_ADD,  0, 0, 32'hFFFF_FFFF, 32'd1);        ev[0] = 32'h0;
    u[1] = mk(3,  OP1_RS1,  OP2_RS2, ALU_SUB,  0, 0, 32'd0, 32'd1);                ev[1] = 32'hFFFF_FFFF;
    u[2] = mk(4,  OP1_RS1,  OP2_RS2, ALU_SRA,  0, 0, 32'h8000_0000, 32'd4);        ev[2] = 32'hF800_0000;
    u[3] = mk(5,  OP1_RS1,  OP2_RS2, ALU_SRL,  0, 0, 32'h8000_0000, 32'd4);        ev[3] = 32'h0800_0000;
    u[4] = mk(6,  OP1_RS1,  OP2_RS2, ALU_SLT,  0, 0, 32'hFFFF_FFFF, 32'd1);        ev[4] = 32'h1;
    u[5] = mk(7,  OP1_RS1,  OP2_RS2, ALU_SLTU, 0, 0, 32'hFFFF_FFFF, 32'd1);        ev[5] = 32'h0;
    u[6] = mk(8,  OP1_RS1,  OP2_IMM, ALU_SLL,  32'h25, 0, 32'd1, 32'd0);           ev[6] = 32'h20;
    u[7] = mk(9,  OP1_PC,   OP2_IMM, ALU_ADD,  32'h4, 32'h1000, 32'h55, 32'h66);   ev[7] = 32'h1004;
    u[8] = mk(10, OP1_ZERO, OP2_IMM, ALU_ADD,  32'hABC, 32'h9, 32'h77, 32'h88);    ev[8] = 32'hABC;
    u[9] = mk(11, OP1_RS1,  OP2_RS2, 4'hF,     0, 0, 32'h1234, 32'h5678);          ev[9] = 32'h0;
    cdb_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(u[i], ev[i]);
      int_rs_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (cdb_bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL alu_latency op %0d got valid %b exp 1", i, cdb_bus.valid);
      end
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL alu_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    fu_alu_reg_t a, b, c;
    a = rand_uop(20); b = rand_uop(21); c = rand_uop(22);
    cdb_grant = 1'b0; int_rs_valid = 1'b1;
    fu_alu_reg_in = a;
    @(negedge clk);
    checks++;
    if (fu_alu_ready !== 1'b1) begin errors++; $display("FAIL bp_accept0 got %b exp 1", fu_alu_ready); end
    exp_q.push_back({a.rob_id, a.rd_phy, a.rd_arch, model(a)});
    @(posedge clk); #1;
    fu_alu_reg_in = b;
    @(negedge clk);
    checks++;
    if (fu_alu_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1 got %b exp 1", fu_alu_ready); end
    exp_q.push_back({b.rob_id, b.rd_phy, b.rd_arch, model(b)});
    @(posedge clk); #1;
    fu_alu_reg_in = c;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fu_alu_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready cyc %0d got %b exp 0", i, fu_alu_ready); end
      checks++;
      if (cdb_req !== 1'b1) begin errors++; $display("FAIL bp_full_req cyc %0d got %b exp 1", i, cdb_req); end
      @(posedge clk); #1;
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    checks++;
    if (fu_alu_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_ready got %b exp 0", fu_alu_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (fu_alu_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_ready got %b exp 1", fu_alu_ready); end
    exp_q.push_back({c.rob_id, c.rd_phy, c.rd_arch, model(c)});
    @(posedge clk); #1;
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    fu_alu_reg_t u;
    cdb_grant = 1'b1;
    u = rand_uop(30);
    issue(u, model(u));
    for (int i = 0; i < 5; i++) begin
      u = rand_uop(31 + i);
      fu_alu_reg_in = u;
      @(negedge clk);
      checks++;
      if (fu_alu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp 1", i, fu_alu_ready); end
      checks++;
      if (cdb_bus.valid !== 1'b1) begin errors++; $display("FAIL b2b_gap cyc %0d got %b exp 1", i, cdb_bus.valid); end
      exp_q.push_back({u.rob_id, u.rd_phy, u.rd_arch, model(u)});
      @(posedge clk); #1;
    end
    int_rs_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cdb_bus.valid !== 1'b1) begin errors++; $display("FAIL b2b_last got %b exp 1", cdb_bus.valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cdb_req !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", cdb_req); end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    fu_alu_reg_t u;
    int k = 0;
    int cyc = 0;
    u = rand_uop(40);
    while (k < 7 && cyc < 60) begin
      cdb_grant     = ((cyc % 2) == 0);
      int_rs_valid  = 1'b1;
      fu_alu_reg_in = u;
      @(negedge clk);
      if (fu_alu_ready === 1'b1) begin
        exp_q.push_back({u.rob_id, u.rd_phy, u.rd_arch, model(u)});
        k++;
        u = rand_uop(40 + k);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (k != 7) begin errors++; $display("FAIL wrap_issued got %0d exp 7", k); end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    fu_alu_reg_t u;
    cdb_grant = 1'b0;
    u = rand_uop(50); issue(u, model(u));
    u = rand_uop(51); issue(u, model(u));
    int_rs_valid = 1'b0;
    #2;
    rst = 1'b1;
    cdb_grant = 1'b1;
    #1;
    checks++;
    if (cdb_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req got %b exp 0", cdb_req); end
    checks++;
    if (cdb_bus.valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", cdb_bus.valid); end
    checks++;
    if (fu_alu_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", fu_alu_ready); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cdb_req !== 1'b0) begin errors++; $display("FAIL mid_reset_after_req got %b exp 0", cdb_req); end
    @(posedge clk); #1;
    // pipeline works normally again after the mid-run reset
    u = rand_uop(52);
    issue(u, model(u));
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_reset_drain got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; int_rs_valid = 1'b0; cdb_grant = 1'b0; fu_alu_reg_in = '0;
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
